tick_gen_multi: RTL and testbench

Parametrised multi-channel tick and clock-enable generator. It produces NCH independent divided-down timebases from the system clock for game timers, sprite movement and input sampling. Each channel's divide ratio is programmable at runtime. Ratio changes take effect glitch-free at the channel's next period boundary. All outputs are synchronous one-cycle ticks (plus optional square waves); downstream logic uses them as clock enables and never as clocks.

---
 rtl/tick_gen_pkg.sv | 14 +
 rtl/tick_gen_ch.sv | 86 ++++++++
 rtl/tick_gen_multi.sv | 50 +++++
 tb/tb_tick_gen_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick / clock-enable generator.
// Divisor constants assume a 100 MHz system clock.
package tick_gen_pkg;

    localparam int CW_DEF = 32;

    typedef logic [CW_DEF-1:0] div_t;

    // Terminal counts: period is D+1 clk cycles.
    localparam div_t DIV_100HZ = 32'd999_999;
    localparam div_t DIV_1KHZ  = 32'd99_999;
    localparam div_t DIV_60HZ  = 32'd1_666_665;

endpackage

// File: rtl/tick_gen_ch.sv
// One timebase channel: counter, active and shadow divisors, tick pulse and
// optional square wave (compiled in when TICK_GEN_SQUARE_EN is defined).
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int            CW      = CW_DEF,
    parameter logic [CW-1:0] DEF_DIV = CW'(DIV_100HZ)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          we,
    input  logic [CW-1:0] wdata,
    output logic          tick,
    output logic          sq,
    output logic          pend
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_act;
    logic [CW-1:0] div_sh;
    logic          wrap;

    // A wrap that actually produces a tick; sync suppresses it.
    assign wrap = en && !sync && (cnt == div_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= DEF_DIV;
            div_sh  <= DEF_DIV;
            pend    <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
            if (we) begin
                div_act <= wdata;
                div_sh  <= wdata;
                pend    <= 1'b0;
            end else if (pend) begin
                div_act <= div_sh;
                pend    <= 1'b0;
            end
        end else begin
            if (sync || (cnt == div_act)) begin
                cnt  <= '0;
                tick <= !sync;
                if (pend) begin
                    div_act <= div_sh;
                end
                pend <= 1'b0;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // Applied after the wrap decision so a same-edge write stays pending.
            if (we) begin
                div_sh <= wdata;
                pend   <= 1'b1;
            end
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else if (wrap) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq = sq_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    assign sq          = 1'b0;
`endif

    cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt <= div_act);

endmodule

// File: rtl/tick_gen_multi.sv
// NCH independent programmable tick / clock-enable generators sharing one
// config port. sq is driven only when TICK_GEN_SQUARE_EN is defined.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int            NCH     = 4,
    parameter int            CW      = CW_DEF,
    parameter logic [CW-1:0] DEF_DIV = CW'(DIV_100HZ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [CW-1:0]          cfg_div,
    input  logic [NCH-1:0]         en,
    input  logic                   sync,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq,
    output logic [NCH-1:0]         pend
);

    // cfg_we is a single-cycle strobe with no ready: every write is accepted
    // on the edge it is seen; channel numbers >= NCH match no channel.
    logic [NCH-1:0] ch_we;

    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_we[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_gen_ch #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en[g]),
            .sync  (sync),
            .we    (ch_we[g]),
            .wdata (cfg_div),
            .tick  (tick[g]),
            .sq    (sq[g]),
            .pend  (pend[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: expected tick cycles go into a queue,
// a negedge monitor matches them against the DUT's tick outputs.
module tb_tick_gen_multi;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int W   = 40;

`ifdef TICK_GEN_SQUARE_EN
    localparam logic SQ = 1'b1;
`else
    localparam logic SQ = 1'b0;
`endif

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           cfg_we  = 1'b0;
    logic [1:0]     cfg_ch  = 2'd0;
    logic [CW-1:0]  cfg_div = '0;
    logic [NCH-1:0] en      = '0;
    logic           sync    = 1'b0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [NCH-1:0] pend;

    logic [31:0]    cyc     = 32'd0;
    logic [31:0]    b;
    int             checks  = 0;
    int             errors  = 0;
    logic [W-1:0]   exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    tick_gen_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DEF_DIV (32'd4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .en      (en),
        .sync    (sync),
        .tick    (tick),
        .sq      (sq),
        .pend    (pend)
    );

    // driver tasks
    task automatic wait_to(input logic [31:0] x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input logic [CW-1:0] d);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = d;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic push_tick(input int ch, input logic [31:0] at);
        logic [7:0] c8;
        c8 = 8'(ch);
        exp_q.push_back({at, c8});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] front;
        while (exp_q.size() > 0 && exp_q[0][39:8] < cyc) begin
            front = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL tick_missing: got no tick ch%0d at cyc %0d, want tick", front[7:0], front[39:8]);
        end
        for (int i = 0; i < NCH; i++) begin
            if (tick[i]) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0] == {cyc, 8'(i)}) begin
                    front = exp_q.pop_front();
                end else begin
                    errors++;
                    $display("FAIL tick_unexpected: got tick ch%0d at cyc %0d, want none", i, cyc);
                end
            end
        end
    end

    initial begin
        // reset state, default divisor 4
        wait_to(32'd3);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_sq",   32'(sq),   32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        rst = 1'b0;
        en  = 4'b0001;
        b   = cyc;
        push_tick(0, b + 5);
        push_tick(0, b + 10);
        push_tick(0, b + 15);
        wait_to(b + 5);
        check("t1_sq_rise", 32'(sq[0]), 32'(SQ));
        check("t1_pend", 32'(pend), 32'd0);
        wait_to(b + 10);
        check("t1_sq_fall", 32'(sq[0]), 32'd0);
        wait_to(b + 15);
        en = 4'b0000;
        wait_to(b + 17);

        // pending write mid-period on channel 1 (D=9 -> 2)
        cfg_write(1, 32'd9);
        en[1] = 1'b1;
        b     = cyc;
        push_tick(1, b + 10);
        wait_to(b + 3);
        cfg_write(1, 32'd2);
        check("t2_pend_set", 32'(pend[1]), 32'd1);
        push_tick(1, b + 13);
        push_tick(1, b + 16);
        push_tick(1, b + 19);
        wait_to(b + 9);
        check("t2_pend_hold", 32'(pend[1]), 32'd1);
        wait_to(b + 10);
        check("t2_pend_clr", 32'(pend[1]), 32'd0);
        wait_to(b + 19);
        en[1] = 1'b0;
        wait_to(b + 21);

        // write on the exact wrap edge of channel 2 (D=5 -> 1)
        cfg_write(2, 32'd5);
        en[2] = 1'b1;
        b     = cyc;
        push_tick(2, b + 6);
        push_tick(2, b + 12);
        wait_to(b + 5);
        cfg_write(2, 32'd1);
        check("t3_pend_wrap", 32'(pend[2]), 32'd1);
        push_tick(2, b + 14);
        push_tick(2, b + 16);
        push_tick(2, b + 18);
        wait_to(b + 11);
        check("t3_pend_hold", 32'(pend[2]), 32'd1);
        wait_to(b + 12);
        check("t3_pend_clr", 32'(pend[2]), 32'd0);
        wait_to(b + 18);
        en[2] = 1'b0;
        wait_to(b + 20);

        // sync alignment and suppression, channels 0 and 3 at D=7
        cfg_write(0, 32'd7);
        cfg_write(3, 32'd7);
        en[0] = 1'b1;
        b     = cyc;
        push_tick(0, b + 8);
        wait_to(b + 3);
        en[3] = 1'b1;
        push_tick(3, b + 11);
        push_tick(0, b + 16);
        push_tick(3, b + 19);
        push_tick(0, b + 28);
        push_tick(3, b + 28);
        push_tick(0, b + 44);
        push_tick(3, b + 44);
        wait_to(b + 19);
        sync = 1'b1;
        wait_to(b + 20);
        sync = 1'b0;
        wait_to(b + 35);
        sync = 1'b1;
        wait_to(b + 36);
        sync = 1'b0;
        check("t4_sync_supp", 32'(tick), 32'd0);
        wait_to(b + 44);
        en = 4'b0000;
        wait_to(b + 46);

        // D=0 written while disabled: every-cycle ticks, never pending
        cfg_write(1, 32'd0);
        check("t5_pend_dis", 32'(pend[1]), 32'd0);
        en[1] = 1'b1;
        b     = cyc;
        for (int t = 1; t <= 5; t++) push_tick(1, b + 32'(t));
        wait_to(b + 3);
        check("t5_pend_d0", 32'(pend[1]), 32'd0);
        wait_to(b + 5);
        en[1] = 1'b0;
        wait_to(b + 7);

        // en dropped mid-period on channel 2 (sq holds), then re-enabled
        cfg_write(2, 32'd5);
        en[2] = 1'b1;
        b     = cyc;
        wait_to(b + 3);
        en[2] = 1'b0;
        wait_to(b + 6);
        check("t5_sq_held", 32'(sq[2]), 32'(SQ));
        wait_to(b + 8);
        en[2] = 1'b1;
        b     = cyc;
        push_tick(2, b + 6);
        wait_to(b + 5);
        check("t5_sq_pre", 32'(sq[2]), 32'(SQ));
        wait_to(b + 6);
        check("t5_sq_tog", 32'(sq[2]), 32'd0);
        en[2] = 1'b0;
        wait_to(b + 8);

        // all channels D=0, reset mid-run restores DEF_DIV and clears outputs
        for (int c = 0; c < NCH; c++) cfg_write(c, 32'd0);
        en = 4'b1111;
        b  = cyc;
        for (int t = 1; t <= 3; t++) begin
            for (int c = 0; c < NCH; c++) push_tick(c, b + 32'(t));
        end
        wait_to(b + 3);
        #2 rst = 1'b1;
        wait_to(b + 4);
        check("t6_rst_tick", 32'(tick), 32'd0);
        check("t6_rst_pend", 32'(pend), 32'd0);
        check("t6_rst_sq",   32'(sq),   32'd0);
        wait_to(b + 5);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) push_tick(c, b + 10);
        for (int c = 0; c < NCH; c++) push_tick(c, b + 15);
        wait_to(b + 10);
        check("t6_sq_all", 32'(sq), 32'({4{SQ}}));
        wait_to(b + 15);
        en = 4'b0000;
        wait_to(b + 18);

        check("end_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
